issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
//  Unified reservation station between rename/dispatch and the execute stage of O3O_CPU.
//  Holds renamed micro-ops until both source physical registers are ready.
//  Wakes up operands from the CDB broadcast.
//  Issues one micro-op per cycle, oldest first by ROB age, to execution.
// PARAMETERS
//  NUM_RS_ENTRIES  16  queue depth, power of two, >=2
//  PHY_WIDTH       6   physical register tag width (PHY_REGS = 2**PHY_WIDTH)
//  ROB_WIDTH       5   ROB index width
//  UOP_WIDTH       32  opaque decoded micro-op payload (instr word + decoded ctrl)
// PORTS
//  clk            in   1               clock
//  rst            in   1               reset, asynchronous, active-high
//  flush          in   1               mispredict/exception flush, synchronous
//  rob_head       in   ROB_WIDTH       oldest in-flight ROB index, used for age compare
//  disp_valid     in   1               dispatch request
//  disp_ready     out  1               a free entry exists
//  disp_uop       in   UOP_WIDTH       micro-op payload
//  disp_rs1_tag   in   PHY_WIDTH       src1 physical tag
//  disp_rs1_rdy   in   1               src1 already valid in PRF
//  disp_rs2_tag   in   PHY_WIDTH       src2 physical tag
//  disp_rs2_rdy   in   1               src2 already valid in PRF
//  disp_rd_tag    in   PHY_WIDTH       destination physical tag
//  disp_rob_idx   in   ROB_WIDTH       ROB slot of the micro-op
//  cdb_valid      in   1               writeback broadcast valid
//  cdb_tag        in   PHY_WIDTH       physical tag being written
//  issue_valid    out  1               selected entry is ready to go
//  issue_ready    in   1               execute stage accepts
//  issue_uop      out  UOP_WIDTH       payload of selected entry
//  issue_rs1_tag  out  PHY_WIDTH       src1 tag, for the PRF read
//  issue_rs2_tag  out  PHY_WIDTH       src2 tag
//  issue_rd_tag   out  PHY_WIDTH       dest tag
//  issue_rob_idx  out  ROB_WIDTH       ROB slot
//  occupancy      out  $clog2(N)+1     count of valid entries, registered
// BEHAVIOUR
//  Reset:
//  - All entry valid bits are 0 and occupancy is 0, so disp_ready=1 and issue_valid=0.
//  - Payload/tag outputs are 0 while issue_valid=0.
//  Dispatch:
//  - A dispatch fires when disp_valid && disp_ready. It writes the lowest-index free entry.
//  - disp_ready = (occupancy != NUM_RS_ENTRIES). It depends on registered state only.
//  - An entry freed by an issue in the same cycle is not reusable until the next cycle.
//  Wakeup:
//  - Each cycle, any valid entry with a source tag == cdb_tag while cdb_valid sets that source rdy.
//  - Same-cycle bypass: a dispatching source whose tag matches the CDB is written with rdy=1.
//  - Tag 0 (x0 mapping) is always ready. Rename guarantees this, and the queue does not special-case it.
//  Select and issue:
//  - Candidates are valid && rs1_rdy && rs2_rdy, using registered rdy bits.
//  - A wakeup in cycle t therefore allows issue in cycle t+1 at the earliest.
//  - The winner is the candidate with minimum (rob_idx - rob_head) mod 2**ROB_WIDTH.
//  - Ties cannot occur, because ROB indices are unique.
//  - issue_valid is combinational from registered state.
//  - The entry is freed at the clock edge where issue_valid && issue_ready.
//  - When issue_ready=0, outputs stay stable unless a newly-ready older entry wins next cycle. Execute must not assume sticky selection.
//  Counts:
//  - occupancy next = occupancy + dispatch_fire - issue_fire.
//  - Simultaneous dispatch and issue leaves occupancy unchanged.
//  Flush:
//  - flush clears all valid bits at the edge and sets occupancy to 0.
//  - Dispatch and issue are ignored in a flush cycle.
//  - issue_valid is still visible in the flush cycle, so execute must gate with flush.
//  - rst asserted mid-operation returns to the reset state immediately.
//  Errors:
//  - Dispatch when full is dropped.
//  - A simulation assertion fires on disp_valid && !disp_ready only if the upstream stage violates the handshake.
// STRUCTURE
//  - parameter_pkg: NUM_RS_ENTRIES, PHY_WIDTH, ROB_WIDTH, UOP_WIDTH.
//  - typedef_pkg: rs_entry_t {valid, uop, rs1_tag, rs1_rdy, rs2_tag, rs2_rdy, rd_tag, rob_idx}.
//  - Sub-module age_select: combinational oldest-ready picker; in = request vector, rob_idx array, rob_head; out = grant one-hot, grant_idx, any.
//  - issue_queue holds the entry array, wakeup compare, free-slot priority encoder, and occupancy counter.
// TESTING
//  1. Reset, then dispatch rs1=5 rdy, rs2=6 rdy, rob=3, issue_ready=1
//     -> issue_valid in the next cycle with rob_idx=3; occupancy goes 1 then 0.
//  2. Dispatch rs1=9 not ready; hold 3 cycles; cdb_valid with tag=9 at cycle 4
//     -> issue_valid=1 at cycle 5, not before.
//  3. Dispatch rs2=12 not ready while cdb_tag=12 is valid in the same cycle
//     -> entry issues in the next cycle (bypass).
//  4. rob_head=30, ready entries rob=1 and rob=31 -> 31 issues first, then 1 (wrap-around age).
//  5. Fill 16 entries with issue_ready=0 -> disp_ready=0 and occupancy=16.
//     Then, in one cycle with issue_ready=1 and disp_valid=1, one issues and the dispatch is refused; occupancy=15.
//  6. 8 entries valid, flush=1 with disp_valid=1 -> next cycle occupancy=0, issue_valid=0, dispatch not captured.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared sizing, entry layout and age helper for the issue queue.
// Every other issue queue file imports this package.
package issue_queue_pkg;

  localparam int NUM_RS_ENTRIES = 16;
  localparam int PHY_WIDTH      = 6;
  localparam int ROB_WIDTH      = 5;
  localparam int UOP_WIDTH      = 32;
  localparam int IDX_W          = $clog2(NUM_RS_ENTRIES);
  localparam int OCC_W          = IDX_W + 1;

  // Payload of one reservation-station slot; valid/ready bits live in
  // separately reset vectors so the wide payload needs no reset.
  typedef struct packed {
    logic [UOP_WIDTH-1:0] uop;
    logic [PHY_WIDTH-1:0] rs1_tag;
    logic [PHY_WIDTH-1:0] rs2_tag;
    logic [PHY_WIDTH-1:0] rd_tag;
    logic [ROB_WIDTH-1:0] rob_idx;
  } rs_entry_t;

  // Distance from the ROB head; smaller means older, wrap handled by modulo.
  function automatic logic [ROB_WIDTH-1:0] rob_age(input logic [ROB_WIDTH-1:0] idx,
                                                   input logic [ROB_WIDTH-1:0] head);
    return idx - head;
  endfunction

endpackage

// File: rtl/issue_queue_age_select.sv
// Combinational oldest-ready picker: grants the requester whose ROB index
// is closest to the ROB head.
module issue_queue_age_select
  import issue_queue_pkg::*;
(
  input  logic [NUM_RS_ENTRIES-1:0] req,
  input  logic [ROB_WIDTH-1:0]      rob_idx [NUM_RS_ENTRIES],
  input  logic [ROB_WIDTH-1:0]      rob_head,
  output logic [NUM_RS_ENTRIES-1:0] grant,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      any
);

  logic [ROB_WIDTH-1:0] best_age;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    best_age  = '0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      if (req[i] && (!any || rob_age(rob_idx[i], rob_head) < best_age)) begin
        any       = 1'b1;
        best_age  = rob_age(rob_idx[i], rob_head);
        grant_idx = IDX_W'(i);
      end
    end
    grant[grant_idx] = any;
  end

endmodule

// File: rtl/issue_queue.sv
// Unified reservation station: holds renamed micro-ops, wakes sources from
// the CDB and issues the oldest ready micro-op each cycle.
module issue_queue
  import issue_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [ROB_WIDTH-1:0] rob_head,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [UOP_WIDTH-1:0] disp_uop,
  input  logic [PHY_WIDTH-1:0] disp_rs1_tag,
  input  logic                 disp_rs1_rdy,
  input  logic [PHY_WIDTH-1:0] disp_rs2_tag,
  input  logic                 disp_rs2_rdy,
  input  logic [PHY_WIDTH-1:0] disp_rd_tag,
  input  logic [ROB_WIDTH-1:0] disp_rob_idx,
  input  logic                 cdb_valid,
  input  logic [PHY_WIDTH-1:0] cdb_tag,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [UOP_WIDTH-1:0] issue_uop,
  output logic [PHY_WIDTH-1:0] issue_rs1_tag,
  output logic [PHY_WIDTH-1:0] issue_rs2_tag,
  output logic [PHY_WIDTH-1:0] issue_rd_tag,
  output logic [ROB_WIDTH-1:0] issue_rob_idx,
  output logic [OCC_W-1:0]     occupancy
);

  logic [NUM_RS_ENTRIES-1:0] valid, rs1_rdy, rs2_rdy;
  logic [NUM_RS_ENTRIES-1:0] valid_nxt, rs1_nxt, rs2_nxt;
  logic [NUM_RS_ENTRIES-1:0] wake1, wake2, req, grant;
  rs_entry_t                 ent     [NUM_RS_ENTRIES];
  logic [ROB_WIDTH-1:0]      ent_rob [NUM_RS_ENTRIES];
  logic [IDX_W-1:0]          free_idx, grant_idx;
  logic                      any, disp_fire, issue_fire;
  rs_entry_t                 sel;

  assign disp_ready = (occupancy != OCC_W'(NUM_RS_ENTRIES));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign issue_fire = issue_valid && issue_ready && !flush;

  // Lowest-index free slot; only meaningful when disp_ready is high.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_RS_ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IDX_W'(i);
  end

  always_comb begin
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      wake1[i]   = cdb_valid && (ent[i].rs1_tag == cdb_tag);
      wake2[i]   = cdb_valid && (ent[i].rs2_tag == cdb_tag);
      ent_rob[i] = ent[i].rob_idx;
    end
  end

  assign req = valid & rs1_rdy & rs2_rdy;

  issue_queue_age_select u_age_select (
    .req       (req),
    .rob_idx   (ent_rob),
    .rob_head  (rob_head),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign issue_valid   = any;
  assign sel           = any ? ent[grant_idx] : '0;
  assign issue_uop     = sel.uop;
  assign issue_rs1_tag = sel.rs1_tag;
  assign issue_rs2_tag = sel.rs2_tag;
  assign issue_rd_tag  = sel.rd_tag;
  assign issue_rob_idx = sel.rob_idx;

  // Issued slot is released here; the free-slot search used the old valid
  // vector, so a slot freed this cycle is never refilled in the same cycle.
  always_comb begin
    valid_nxt = valid;
    rs1_nxt   = rs1_rdy | wake1;
    rs2_nxt   = rs2_rdy | wake2;
    if (issue_fire) valid_nxt = valid_nxt & ~grant;
    if (disp_fire) begin
      valid_nxt[free_idx] = 1'b1;
      rs1_nxt[free_idx]   = disp_rs1_rdy || (cdb_valid && (disp_rs1_tag == cdb_tag));
      rs2_nxt[free_idx]   = disp_rs2_rdy || (cdb_valid && (disp_rs2_tag == cdb_tag));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= '0;
      rs1_rdy   <= '0;
      rs2_rdy   <= '0;
      occupancy <= '0;
    end else if (flush) begin
      valid     <= '0;
      occupancy <= '0;
    end else begin
      valid     <= valid_nxt;
      rs1_rdy   <= rs1_nxt;
      rs2_rdy   <= rs2_nxt;
      occupancy <= occupancy + OCC_W'(disp_fire) - OCC_W'(issue_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (disp_fire)
      ent[free_idx] <= '{uop: disp_uop, rs1_tag: disp_rs1_tag, rs2_tag: disp_rs2_tag,
                         rd_tag: disp_rd_tag, rob_idx: disp_rob_idx};
  end

  // A refused dispatch must be held unchanged until the queue accepts it.
  a_disp_hold: assert property (@(posedge clk) disable iff (rst)
    (disp_valid && !disp_ready && !flush) |=>
    (disp_valid && $stable(disp_uop) && $stable(disp_rob_idx)));

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: expected issues are queued at dispatch
// and compared whenever the queue hands a micro-op to execute.
module tb_issue_queue;
  import issue_queue_pkg::*;

  typedef struct packed {
    logic [UOP_WIDTH-1:0] uop;
    logic [PHY_WIDTH-1:0] rs1;
    logic [PHY_WIDTH-1:0] rs2;
    logic [PHY_WIDTH-1:0] rd;
    logic [ROB_WIDTH-1:0] rob;
  } exp_t;

  logic                 clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [ROB_WIDTH-1:0] rob_head = '0;
  logic                 disp_valid = 1'b0, disp_ready;
  logic [UOP_WIDTH-1:0] disp_uop = '0;
  logic [PHY_WIDTH-1:0] disp_rs1_tag = '0, disp_rs2_tag = '0, disp_rd_tag = '0;
  logic                 disp_rs1_rdy = 1'b0, disp_rs2_rdy = 1'b0;
  logic [ROB_WIDTH-1:0] disp_rob_idx = '0;
  logic                 cdb_valid = 1'b0;
  logic [PHY_WIDTH-1:0] cdb_tag = '0;
  logic                 issue_valid, issue_ready = 1'b0;
  logic [UOP_WIDTH-1:0] issue_uop;
  logic [PHY_WIDTH-1:0] issue_rs1_tag, issue_rs2_tag, issue_rd_tag;
  logic [ROB_WIDTH-1:0] issue_rob_idx;
  logic [OCC_W-1:0]     occupancy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_uop(disp_uop),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs1_rdy(disp_rs1_rdy),
    .disp_rs2_tag(disp_rs2_tag), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rd_tag(disp_rd_tag), .disp_rob_idx(disp_rob_idx),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_uop(issue_uop),
    .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
    .issue_rd_tag(issue_rd_tag), .issue_rob_idx(issue_rob_idx),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input logic [UOP_WIDTH-1:0] uop,
                            input logic [PHY_WIDTH-1:0] rs1, input logic r1,
                            input logic [PHY_WIDTH-1:0] rs2, input logic r2,
                            input logic [PHY_WIDTH-1:0] rd,
                            input logic [ROB_WIDTH-1:0] rob);
    disp_valid   = 1'b1;
    disp_uop     = uop;
    disp_rs1_tag = rs1;
    disp_rs1_rdy = r1;
    disp_rs2_tag = rs2;
    disp_rs2_rdy = r2;
    disp_rd_tag  = rd;
    disp_rob_idx = rob;
  endtask

  function automatic exp_t mk(input logic [UOP_WIDTH-1:0] uop, input logic [PHY_WIDTH-1:0] rs1,
                              input logic [PHY_WIDTH-1:0] rs2, input logic [PHY_WIDTH-1:0] rd,
                              input logic [ROB_WIDTH-1:0] rob);
    return '{uop: uop, rs1: rs1, rs2: rs2, rd: rd, rob: rob};
  endfunction

  // Compare every accepted issue against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready && !flush) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(issue_rob_idx), 64'h3f);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("issue_bundle",
              64'({issue_uop, issue_rs1_tag, issue_rs2_tag, issue_rd_tag, issue_rob_idx}),
              64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_occ", 64'(occupancy), 0);
    check("rst_disp_ready", 64'(disp_ready), 1);
    check("rst_issue_valid", 64'(issue_valid), 0);
    rst = 1'b0;
    tick();
    check("idle_issue_uop", 64'(issue_uop), 0);
    check("idle_issue_rob", 64'(issue_rob_idx), 0);

    // Simple ready dispatch issues the next cycle
    issue_ready = 1'b1;
    drive_disp(32'hA000_0001, 6'd5, 1'b1, 6'd6, 1'b1, 6'd7, 5'd3);
    sb.push_back(mk(32'hA000_0001, 6'd5, 6'd6, 6'd7, 5'd3));
    tick();
    disp_valid = 1'b0;
    check("t1_occ1", 64'(occupancy), 1);
    check("t1_issue_valid", 64'(issue_valid), 1);
    check("t1_rob", 64'(issue_rob_idx), 3);
    tick();
    check("t1_occ0", 64'(occupancy), 0);
    check("t1_drained", 64'(issue_valid), 0);

    // CDB wakeup permits issue one cycle after the broadcast
    drive_disp(32'hB000_0002, 6'd9, 1'b0, 6'd6, 1'b1, 6'd8, 5'd4);
    sb.push_back(mk(32'hB000_0002, 6'd9, 6'd6, 6'd8, 5'd4));
    tick();
    disp_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("t2_wait_c%0d", c), 64'(issue_valid), 0);
      tick();
    end
    cdb_valid = 1'b1;
    cdb_tag   = 6'd9;
    check("t2_cdb_cycle", 64'(issue_valid), 0);
    tick();
    cdb_valid = 1'b0;
    check("t2_woken", 64'(issue_valid), 1);
    tick();
    check("t2_occ0", 64'(occupancy), 0);

    // Same-cycle CDB bypass on dispatch
    drive_disp(32'hC000_0003, 6'd5, 1'b1, 6'd12, 1'b0, 6'd13, 5'd5);
    cdb_valid = 1'b1;
    cdb_tag   = 6'd12;
    sb.push_back(mk(32'hC000_0003, 6'd5, 6'd12, 6'd13, 5'd5));
    tick();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    check("t3_bypass", 64'(issue_valid), 1);
    check("t3_rob", 64'(issue_rob_idx), 5);
    tick();
    check("t3_occ0", 64'(occupancy), 0);

    // Wrap-around age: head 30, rob 31 is older than rob 1
    issue_ready = 1'b0;
    rob_head    = 5'd30;
    sb.push_back(mk(32'hD000_001F, 6'd1, 6'd2, 6'd3, 5'd31));
    sb.push_back(mk(32'hD000_0001, 6'd1, 6'd2, 6'd4, 5'd1));
    drive_disp(32'hD000_0001, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4, 5'd1);
    tick();
    drive_disp(32'hD000_001F, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 5'd31);
    tick();
    disp_valid = 1'b0;
    check("t4_occ2", 64'(occupancy), 2);
    check("t4_oldest_first", 64'(issue_rob_idx), 31);
    issue_ready = 1'b1;
    tick();
    check("t4_then_young", 64'(issue_rob_idx), 1);
    tick();
    check("t4_occ0", 64'(occupancy), 0);
    issue_ready = 1'b0;
    rob_head    = 5'd0;

    // Fill the queue, then refuse a dispatch while one entry issues
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      drive_disp(32'hF000_0000 + 32'(i), 6'd20, 1'b1, 6'd21, 1'b1, 6'(i), 5'(i));
      sb.push_back(mk(32'hF000_0000 + 32'(i), 6'd20, 6'd21, 6'(i), 5'(i)));
      tick();
    end
    disp_valid = 1'b0;
    check("t5_full_ready", 64'(disp_ready), 0);
    check("t5_full_occ", 64'(occupancy), 16);
    issue_ready = 1'b1;
    drive_disp(32'hE000_0010, 6'd20, 1'b1, 6'd21, 1'b1, 6'd30, 5'd16);
    sb.push_back(mk(32'hE000_0010, 6'd20, 6'd21, 6'd30, 5'd16));
    tick();
    issue_ready = 1'b0;
    check("t5_refused_occ", 64'(occupancy), 15);
    check("t5_ready_again", 64'(disp_ready), 1);
    tick();
    disp_valid = 1'b0;
    check("t5_held_accepted", 64'(occupancy), 16);

    // Drain to 8 entries, then flush with a dispatch pending
    issue_ready = 1'b1;
    repeat (8) tick();
    issue_ready = 1'b0;
    check("t6_occ8", 64'(occupancy), 8);
    flush       = 1'b1;
    issue_ready = 1'b1;
    drive_disp(32'h5555_0014, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 5'd20);
    check("t6_visible_in_flush", 64'(issue_valid), 1);
    tick();
    flush       = 1'b0;
    disp_valid  = 1'b0;
    issue_ready = 1'b0;
    sb.delete();
    check("t6_occ0", 64'(occupancy), 0);
    check("t6_issue_valid", 64'(issue_valid), 0);
    check("t6_uop_zero", 64'(issue_uop), 0);
    tick();
    check("t6_not_captured", 64'(occupancy), 0);

    // Asynchronous reset mid-operation
    drive_disp(32'h7777_0001, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 5'd7);
    tick();
    disp_valid = 1'b0;
    check("t7_occ1", 64'(occupancy), 1);
    #2 rst = 1'b1;
    #1;
    check("t7_async_occ", 64'(occupancy), 0);
    check("t7_async_issue", 64'(issue_valid), 0);
    tick();
    rst = 1'b0;
    tick();
    check("t7_after_rst", 64'(disp_ready), 1);

    check("sb_drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
